// File: rtl/step_seq_pkg.sv
// Shared state encoding and default timing constants for the stepper motion sequencer.
package step_seq_pkg;

    localparam int START_PERIOD_DEF = 2000;
    localparam int RAMP_DELTA_DEF   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_CRUISE,
        S_DECEL,
        S_FINISH
    } seq_state_t;

endpackage

// File: rtl/step_ramp_calc.sv
// Saturating period step: shorten toward target while accelerating,
// lengthen toward START_PERIOD while decelerating.
module step_ramp_calc
    import step_seq_pkg::*;
#(
    parameter int SIZE         = 16,
    parameter int START_PERIOD = START_PERIOD_DEF,
    parameter int RAMP_DELTA   = RAMP_DELTA_DEF
) (
    input  logic [SIZE-1:0] cur,
    input  logic [SIZE-1:0] target,
    input  logic            up,
    output logic [SIZE-1:0] nxt
);

    localparam logic [SIZE:0] DELTA = (SIZE+1)'(RAMP_DELTA);
    localparam logic [SIZE:0] START = (SIZE+1)'(START_PERIOD);

    logic [SIZE:0] sum;
    logic [SIZE:0] diff;

    // One extra bit so a borrow below zero is visible as diff[SIZE].
    assign sum  = {1'b0, cur} + DELTA;
    assign diff = {1'b0, cur} - DELTA;

    always_comb begin
        if (up)
            nxt = (sum > START) ? START[SIZE-1:0] : sum[SIZE-1:0];
        else
            nxt = (diff[SIZE] || (diff < {1'b0, target})) ? target : diff[SIZE-1:0];
    end

endmodule

// File: rtl/step_seq_ctrl.sv
// Trapezoidal move sequencer driving the stepper-pulse generator.
// Define STEP_SEQ_DECEL_EN to build the ramp-down phase and the decelerating abort.
module step_seq_ctrl
    import step_seq_pkg::*;
#(
    parameter int SIZE         = 16,
    parameter int CNT_W        = 24,
    parameter int START_PERIOD = START_PERIOD_DEF,
    parameter int RAMP_DELTA   = RAMP_DELTA_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [SIZE-1:0]  cmd_period,
    input  logic             cmd_dir,
    input  logic             abort,
    input  logic             step_tick,
    output logic             run,
    output logic [SIZE-1:0]  period,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    localparam logic [SIZE-1:0] START_P = SIZE'(START_PERIOD);

    seq_state_t       state, tk_state, nx_state;
    logic [SIZE-1:0]  target, ramp_nxt, tk_period;
    logic [CNT_W-1:0] accel_cnt, tk_cnt, tk_left, nx_left;
    logic             ticked;

    assign cmd_ready = (state == S_IDLE) && !rst;
    assign ticked    = step_tick && (state inside {S_ACCEL, S_CRUISE, S_DECEL});

    step_ramp_calc #(
        .SIZE         (SIZE),
        .START_PERIOD (START_PERIOD),
        .RAMP_DELTA   (RAMP_DELTA)
    ) u_ramp (
        .cur    (period),
        .target (target),
        .up     (state == S_DECEL),
        .nxt    (ramp_nxt)
    );

    // Effect of a generator pulse alone; abort is layered on top afterwards.
    always_comb begin
        tk_state  = state;
        tk_period = period;
        tk_cnt    = accel_cnt;
        tk_left   = steps_left;
        if (ticked) begin
            tk_left = steps_left - 1'b1;
            case (state)
                S_ACCEL: begin
                    tk_period = ramp_nxt;
                    tk_cnt    = accel_cnt + 1'b1;
`ifdef STEP_SEQ_DECEL_EN
                    if (tk_left <= tk_cnt)
                        tk_state = S_DECEL;
                    else if (ramp_nxt == target)
                        tk_state = S_CRUISE;
`else
                    if (ramp_nxt == target)
                        tk_state = S_CRUISE;
`endif
                end
`ifdef STEP_SEQ_DECEL_EN
                S_CRUISE: if (tk_left <= accel_cnt) tk_state = S_DECEL;
                S_DECEL:  tk_period = ramp_nxt;
`endif
                default: ;
            endcase
            if (tk_left == '0)
                tk_state = S_FINISH;
        end
    end

    always_comb begin
        nx_state = tk_state;
        nx_left  = tk_left;
        if (abort && (tk_state == S_ACCEL || tk_state == S_CRUISE)) begin
`ifdef STEP_SEQ_DECEL_EN
            // Only as many steps remain as it took to get up to speed.
            nx_left  = (tk_left < tk_cnt) ? tk_left : tk_cnt;
            nx_state = (nx_left == '0) ? S_FINISH : S_DECEL;
`else
            nx_state = S_FINISH;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            run        <= 1'b0;
            period     <= START_P;
            target     <= START_P;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
            accel_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        steps_left <= cmd_steps;
                        target     <= cmd_period;
                        dir        <= cmd_dir;
                        accel_cnt  <= '0;
                        busy       <= 1'b1;
                        if (cmd_steps == '0) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end else if (cmd_period < START_P) begin
                            state  <= S_ACCEL;
                            period <= START_P;
                            run    <= 1'b1;
                        end else begin
                            state  <= S_CRUISE;
                            period <= cmd_period;
                            run    <= 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    run   <= 1'b0;
                end
                default: begin
                    state      <= nx_state;
                    period     <= tk_period;
                    accel_cnt  <= tk_cnt;
                    steps_left <= nx_left;
                    run        <= (nx_state != S_FINISH);
                    done       <= (nx_state == S_FINISH);
                end
            endcase
        end
    end

endmodule

// File: doc/step_seq_ctrl.md
# step_seq_ctrl

Motion sequencer for the stepper-pulse generator. It accepts move commands (step count, target period, direction) over a valid/ready handshake. It then drives the generator's period, enable and direction so the motor follows a trapezoidal profile: ramp up from a safe start rate, cruise, ramp back down. Progress is tracked through the generator's per-pulse strobe, and completion is reported to the command source.

## Interface
Parameters:
- SIZE, 16, period width in clk cycles.
- CNT_W, 24, step-count width.
- START_PERIOD, 2000, start/stop period (25 kHz at 50 MHz).
- RAMP_DELTA, 8, period change per step while ramping.

Ports:
- clk  in  1  50 MHz clock.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE and not in rst.
- cmd_steps  in  CNT_W  pulses to emit.
- cmd_period  in  SIZE  target cruise period.
- cmd_dir  in  1  direction.
- abort  in  1  level; stop current move.
- step_tick  in  1  one-cycle strobe per pulse emitted by the generator.
- run  out  1  generator enable.
- period  out  SIZE  period presented to the generator.
- dir  out  1  direction to driver.
- busy  out  1  move in progress.
- done  out  1  one-cycle completion strobe.
- steps_left  out  CNT_W  remaining pulses.

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL, FINISH.
- **Accept:** a handshake (cmd_valid & cmd_ready) latches steps, target and dir.
  - steps == 0: go to FINISH; run stays 0.
  - target < START_PERIOD: period = START_PERIOD, go to ACCEL.
  - Otherwise: period = target, go to CRUISE.
- **Every step_tick in ACCEL/CRUISE/DECEL:** steps_left decrements.
- **ACCEL, on tick:**
  - period = max(period − RAMP_DELTA, target).
  - accel_cnt increments.
  - If the new steps_left ≤ accel_cnt, go to DECEL; this check has priority and covers the triangle profile.
  - Else if period == target, go to CRUISE.
- **CRUISE, on tick:** if the new steps_left ≤ accel_cnt, go to DECEL.
- **DECEL, on tick:** period = min(period + RAMP_DELTA, START_PERIOD).
- **Any running state:** steps_left reaching 0 goes to FINISH.
- **FINISH:** run = 0, done = 1 for exactly one cycle, then IDLE.
- **Arithmetic:** ramp add/sub is done in SIZE+1 bits and saturated as above. accel_cnt is CNT_W bits and is cleared on accept. Ticks while in IDLE or FINISH are ignored.
- **abort:**
  - Ignored in IDLE, FINISH and DECEL.
  - Handling in ACCEL/CRUISE is per Configuration.

## Timing
- **Reset values:** state IDLE, run 0, period START_PERIOD, dir 0, busy 0, done 0, steps_left 0. accel_cnt is cleared.
- **Reset mid-move:** run drops the next cycle and no done is issued.
- **Accept latency:** handshake at edge N gives run, busy, period and dir valid after N+1. cmd_ready deasserts on the same edge.
- **Tick latency:** period and steps_left update on the edge that samples step_tick, so the generator sees the new period for its next pulse.
- **Completion:** done is high during the FINISH cycle. cmd_ready returns the following cycle.
- **Simultaneous events:** abort and step_tick in the same cycle apply the tick first, then the abort.

## Configuration
- Macro: STEP_SEQ_DECEL_EN.
- **Defined:**
  - DECEL ramp is implemented.
  - abort in ACCEL/CRUISE forces DECEL with steps_left = min(steps_left, accel_cnt); if that value is 0, go to FINISH.
- **Undefined:**
  - No DECEL state and no ramp-down; the move finishes at cruise period.
  - abort in ACCEL/CRUISE goes straight to FINISH: run 0 next cycle, done strobe.

## Structure
- **Package step_seq_pkg:** state enum; default START_PERIOD and RAMP_DELTA constants.
- **Sub-module step_ramp_calc:** combinational saturating period step (up/down, clamp to target or START_PERIOD). It is instantiated once.

## Test plan
- Trapezoid, START=2000, DELTA=8, steps=10, period=1960.
  - Ticks 1–5 give periods 1992, 1984, 1976, 1968, 1960.
  - Ticks 6–10 give 1968, 1976, 1984, 1992, 2000.
  - done on the cycle after tick 10.
- Triangle, steps=4, period=1000.
  - Periods 1992, 1984, then 1992, 2000.
  - DECEL is entered after tick 2; done after tick 4.
- steps=0: done pulses one cycle after the handshake; run never asserts; cmd_ready returns the next cycle.
- Slow target, period=2500, steps=3: period constant at 2500, state CRUISE, done after tick 3.
- Abort in CRUISE (steps=100, period=1960), raised after tick 20.
  - Macro defined: 5 more ticks, period returns to 2000, then done.
  - Macro undefined: run drops next cycle, with done.
- rst asserted mid-ACCEL: the following cycle shows run 0, steps_left 0, period 2000, no done. A new command is accepted normally afterwards.
